// File: rtl/puf_pkg.sv
// Shared types and default constants for the RO PUF response sequencer.
//   seq_state_e        : sequencer FSM states
//   *_DEF localparams  : default parameter values for the sequencer
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    RACE,
    NEXT,
    DONE
  } seq_state_e;

  localparam int RESP_BITS_DEF      = 16;
  localparam int SEL_W_DEF          = 5;
  localparam int SETTLE_CYCLES_DEF  = 4;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/race_timer.sv
// Loadable down-counter with an expired flag.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over counting)
//   load_val   : value to load
//   en         : decrement while nonzero
//   expired    : count has reached zero
// Loading N-1 and leaving on the first expired cycle gives exactly N
// cycles of occupancy in the enabling state.
module race_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)                   count <= '0;
    else if (load)               count <= load_val;
    else if (en && count != '0)  count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/puf_response_sequencer.sv
// Sequencer that drives race_arbiter through RESP_BITS races per challenge
// and assembles the arbiter decisions into a response word (LSB first).
//   clk, reset          : clock, synchronous active-high reset
//   start, challenge    : request a word; challenge is the base RO index
//   arb_done, arb_out   : arbiter handshake (out=1 means oscillator A won)
//   ro_sel_a, ro_sel_b  : oscillator pair for the current race
//   race_reset          : holds race counters/arbiter in reset (low only in RACE)
//   busy                : sequencer not idle
//   resp_valid          : one-cycle pulse, response complete
//   response            : collected word, held until next start or reset
//   timeout_err         : sticky, some race of this word timed out
module puf_response_sequencer
  import puf_pkg::*;
#(
  parameter int RESP_BITS      = RESP_BITS_DEF,
  parameter int SEL_W          = SEL_W_DEF,
  parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SEL_W-1:0]     challenge,
  input  logic                 arb_done,
  input  logic                 arb_out,
  output logic [SEL_W-1:0]     ro_sel_a,
  output logic [SEL_W-1:0]     ro_sel_b,
  output logic                 race_reset,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] response,
  output logic                 timeout_err
);

  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_e       state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             settle_load, settle_exp;
  logic             tmo_load, tmo_exp;
  logic             accept, capture, timed_out, advance;

  race_timer #(.W(SET_W)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (settle_load),
    .load_val (SET_W'(SETTLE_CYCLES - 1)),
    .en       (state == SETTLE),
    .expired  (settle_exp)
  );

  race_timer #(.W(TMO_W)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .load     (tmo_load),
    .load_val (TMO_W'(TIMEOUT_CYCLES - 1)),
    .en       (state == RACE),
    .expired  (tmo_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    settle_load = 1'b0;
    tmo_load    = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    timed_out   = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept      = 1'b1;
        settle_load = 1'b1;
        state_nxt   = SETTLE;
      end
      SETTLE: if (settle_exp) begin
        tmo_load  = 1'b1;
        state_nxt = RACE;
      end
      RACE: begin
        // done takes priority over a coincident timeout
        if (arb_done) begin
          capture   = 1'b1;
          state_nxt = NEXT;
        end else if (tmo_exp) begin
          timed_out = 1'b1;
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (idx == IDX_W'(RESP_BITS - 1)) begin
          state_nxt = DONE;
        end else begin
          advance     = 1'b1;
          settle_load = 1'b1;
          state_nxt   = SETTLE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      response    <= '0;
      timeout_err <= 1'b0;
      ro_sel_a    <= '0;
      ro_sel_b    <= '0;
    end else begin
      if (accept) begin
        idx         <= '0;
        response    <= '0;
        timeout_err <= 1'b0;
        ro_sel_a    <= challenge;
        ro_sel_b    <= challenge + 1'b1;
      end
      if (capture) response[idx] <= arb_out;
      if (timed_out) begin
        response[idx] <= 1'b0;
        timeout_err   <= 1'b1;
      end
      // challenge + 2*i, stepped incrementally; wraps mod 2^SEL_W
      if (advance) begin
        idx      <= idx + 1'b1;
        ro_sel_a <= ro_sel_a + SEL_W'(2);
        ro_sel_b <= ro_sel_a + SEL_W'(3);
      end
    end
  end

  assign race_reset = (state != RACE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);

endmodule

// File: tb/tb_puf_response_sequencer.sv
module tb_puf_response_sequencer;

  localparam int RB  = 16;
  localparam int SW  = 5;
  localparam int SC  = 4;
  localparam int TMO = 4096;

  logic          clk = 0;
  logic          reset, start, arb_done, arb_out;
  logic [SW-1:0] challenge, ro_sel_a, ro_sel_b;
  logic          race_reset, busy, resp_valid, timeout_err;
  logic [RB-1:0] response;

  puf_response_sequencer #(
    .RESP_BITS(RB), .SEL_W(SW), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .arb_done(arb_done), .arb_out(arb_out),
    .ro_sel_a(ro_sel_a), .ro_sel_b(ro_sel_b), .race_reset(race_reset),
    .busy(busy), .resp_valid(resp_valid), .response(response),
    .timeout_err(timeout_err)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0, pulses = 0;
  logic [16:0] exp_q[$];   // {timeout_err, response}

  // arbiter model controls
  int done_at, skip_bit, out_mode, hold_mode, chal, rc;
  int lens[RB];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic bitval(input int r);
    return (out_mode == 1) ? 1'b1 : r[0];
  endfunction

  // Arbiter model: counts RACE cycles, raises done on cycle done_at,
  // records race lengths and checks the oscillator pair per race.
  initial begin
    int run = 0, hi_run = 0;
    arb_done = 0; arb_out = 0;
    forever begin
      @(posedge clk); #1;
      if (!race_reset) begin
        if (run == 0) begin
          chk("ro_sel_a", ro_sel_a, (chal + 2*rc) % 32);
          chk("ro_sel_b", ro_sel_b, (chal + 2*rc + 1) % 32);
          if (rc > 0) chk("gap_next_plus_settle", hi_run, SC + 1);
        end
        run++;
        arb_done = (run == done_at) && (rc != skip_bit);
        arb_out  = bitval(rc);
      end else begin
        if (run != 0) begin
          if (rc < RB) lens[rc] = run;
          rc++;
          run = 0;
          hi_run = 0;
        end
        hi_run++;
        arb_done = hold_mode ? arb_done : 1'b0;
        arb_out  = hold_mode ? ~bitval(rc) : 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic [16:0] e;
    logic prev = 0;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        pulses++;
        chk("resp_valid_single_pulse", prev, 0);
        if (exp_q.size() == 0) chk("resp_valid_without_request", resp_valid, 0);
        else begin
          e = exp_q.pop_front();
          chk("response", response, e[15:0]);
          chk("timeout_err", timeout_err, e[16]);
        end
      end
      prev = resp_valid;
    end
  end

  task automatic do_start(input int ch, input logic [15:0] er, input logic ee);
    @(negedge clk);
    chal = ch; rc = 0;
    exp_q.push_back({ee, er});
    challenge = SW'(ch); start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 10000) begin @(negedge clk); k++; end
    chk("wait_idle_bound", busy, 0);
  endtask

  task automatic wait_race(input int b);
    int k = 0;
    while (!(rc == b && !race_reset) && k < 2000) begin @(negedge clk); k++; end
    chk("wait_race_bound", int'(rc == b && !race_reset), 1);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!resp_valid && k < 2000) begin @(negedge clk); k++; end
    chk("wait_valid_bound", resp_valid, 1);
  endtask

  initial begin
    reset = 1; start = 0; challenge = 0;
    done_at = 10; skip_bit = 99; out_mode = 0; hold_mode = 0; chal = 0; rc = 0;
    repeat (3) @(negedge clk);
    chk("rst_race_reset", race_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_response", response, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_ro_sel_a", ro_sel_a, 0);
    chk("rst_ro_sel_b", ro_sel_b, 0);
    reset = 0;

    // 1: alternating bits, done 10 cycles into each race
    do_start(5, 16'hAAAA, 0);
    wait_idle();
    chk("t1_len0", lens[0], 10);
    chk("t1_len15", lens[15], 10);

    // 2: selection wraps past 31
    do_start(30, 16'hAAAA, 0);
    wait_idle();

    // 3: race 3 times out, others win A
    out_mode = 1; skip_bit = 3;
    do_start(7, 16'hFFF7, 1);
    wait_idle();
    chk("t3_len3_timeout", lens[3], TMO);
    chk("t3_len2", lens[2], 10);

    // 4: starts during RACE and in the resp_valid cycle are ignored
    out_mode = 0; skip_bit = 99;
    do_start(9, 16'hAAAA, 0);
    wait_race(2);
    challenge = 20; start = 1;
    @(negedge clk);
    start = 0;
    wait_valid();
    start = 1;
    @(negedge clk);
    start = 0;
    chk("t4_busy_after_ignored_start", busy, 0);
    repeat (3) @(negedge clk);
    chk("t4_still_idle", busy, 0);

    // 5: reset during bit 7 aborts the word
    out_mode = 1;
    do_start(3, 16'h0000, 0);
    wait_race(7);
    reset = 1;
    void'(exp_q.pop_back());
    @(negedge clk);
    chk("t5_race_reset", race_reset, 1);
    chk("t5_busy", busy, 0);
    chk("t5_response_cleared", response, 0);
    chk("t5_resp_valid", resp_valid, 0);
    chk("t5_timeout_err", timeout_err, 0);
    reset = 0;
    done_at = 2;
    do_start(0, 16'hFFFF, 0);
    wait_idle();
    chk("t5_len8", lens[8], 2);

    // 6: stale done held through NEXT/SETTLE with inverted out
    hold_mode = 1; out_mode = 0; done_at = 3;
    do_start(12, 16'hAAAA, 0);
    wait_idle();
    chk("t6_len5", lens[5], 3);

    repeat (3) @(negedge clk);
    chk("resp_valid_count", pulses, 6);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
